mmx_writeback_stage: RTL
========================

// Module: mmx_writeback_stage
// PURPOSE
//  Final MMX pipeline stage: buffers 64-bit MMX results from execute in a small FIFO and retires one per
//  cycle onto the register-file write port (writeback_data/select/enable into mmx_register_file).
//  Publishes a pending-write mask so decode/read stalls on RAW hazards; optional bypass of buffered results.
// PARAMETERS
//  DEPTH    2   FIFO entries (power of 2, >=2)
//  DATA_W   64  MMX register width
//  SEL_W    3   register select width (8 regs MM0-MM7)
// PORTS
//  clk               in   1       rising-edge clock
//  reset             in   1       asynchronous, active-high reset
//  ex_valid          in   1       execute offers a result
//  ex_ready          out  1       stage can accept (combinational from count)
//  ex_data           in   DATA_W  result value
//  ex_dest           in   SEL_W   destination MMx
//  hold              in   1       pipeline hold: no retirement this cycle
//  flush             in   1       synchronous kill of all buffered, unretired results
//  writeback_data    out  DATA_W  registered write data to register file
//  writeback_select  out  SEL_W   registered destination
//  writeback_enable  out  1       registered write strobe
//  pending_mask      out  8       bit i = write to MMi buffered or on write port
//  byp_sel           in   SEL_W   bypass lookup select        (MMX_BYPASS_EN only)
//  byp_hit           out  1       pending value exists        (MMX_BYPASS_EN only)
//  byp_data          out  DATA_W  youngest pending value      (MMX_BYPASS_EN only)
// BEHAVIOUR
//  - Reset (async): FIFO empty, count=0, writeback_enable=0, writeback_data=0, writeback_select=0, pending_mask=0.
//  - Accept: ex_valid && ex_ready at edge -> entry {ex_data,ex_dest} pushed at tail. ex_ready = (count<DEPTH);
//    no pass-through when full (pop in same cycle does not raise ex_ready).
//  - Retire: each edge with count>0 && !hold && !flush -> head popped, writeback_* loaded, enable=1.
//    Otherwise writeback_enable<=0 (data/select hold last value). Min latency: pushed at edge N, strobe
//    high N+1..N+2, register file captures at N+2.
//  - Simultaneous push+pop: count unchanged, order preserved; pointers wrap mod DEPTH.
//  - hold: FIFO keeps contents, pushes still allowed while not full; enable drops next edge.
//  - flush: highest priority; at edge clears count/pointers, discards concurrent push, enable<=0.
//    A write already on writeback_* during the flush cycle still completes (already committed).
//  - pending_mask = OR of one-hot(dest) over valid FIFO entries, OR one-hot(writeback_select) if enable.
//    Combinational from registered state; no dependence on ex_* inputs.
//  - Same-dest entries legal; retirement strictly in order, so last write wins in register file.
// CONFIGURATION
//  MMX_BYPASS_EN defined: byp_hit/byp_data combinational lookup over FIFO entries + write port register;
//    priority youngest FIFO entry > older entries > writeback register; byp_hit=0, byp_data=0 if no match.
//  Not defined: byp_* ports absent; consumers stall on pending_mask only.
// STRUCTURE
//  - Shared package mmx_pkg: MMX_DATA_W=64, MMX_SEL_W=3, MMX_NUM_REGS=8, typedef mmx_wb_entry_t {data,dest}.
//  - Sub-module mmx_wb_fifo: DEPTH-entry circular FIFO (push/pop/flush, count, full/empty, entry+valid
//    vectors exported for mask/bypass). Top holds write-port registers, mask and bypass logic.
// TESTING
//  1 Reset mid-stream: 2 entries buffered, assert reset -> all outputs 0 immediately, ex_ready=1 after.
//  2 Single push MM3=0x1234_5678_9ABC_DEF0, hold=0 -> enable high 1 cycle, select=3, pending_mask 0x08
//    until enable drops; mmx_register_file mm3_out matches.
//  3 Back-to-back 8 pushes MM0..MM7 with hold=1 -> ex_ready=0 after 2; release hold -> in-order retire,
//    one per cycle, no lost/duplicated writes.
//  4 Push MM5=0xA then MM5=0xB -> two in-order writes, mm5_out=0xB; bypass byp_sel=5 returns 0xB while pending.
//  5 Fill FIFO, assert flush with ex_valid=1 -> count=0, pending_mask=0 next edge, no writeback_enable.
//  6 Full FIFO + hold=0 + ex_valid=1 -> ex_ready stays 0 that cycle; push accepted next cycle.

Source files
------------

// File: rtl/mmx_pkg.sv
// Shared MMX writeback definitions: register-file geometry and the buffered result entry.
package mmx_pkg;
   localparam int MMX_DATA_W   = 64;
   localparam int MMX_SEL_W    = 3;
   localparam int MMX_NUM_REGS = 8;

   typedef struct packed {
      logic [MMX_DATA_W-1:0] data;
      logic [MMX_SEL_W-1:0]  dest;
   } mmx_wb_entry_t;

   function automatic logic [MMX_NUM_REGS-1:0] mmx_onehot(input logic [MMX_SEL_W-1:0] sel);
      return MMX_NUM_REGS'(1) << sel;
   endfunction
endpackage

// File: rtl/mmx_wb_fifo.sv
// Circular result buffer for the MMX writeback stage. Flush dominates push/pop; the entry and
// valid vectors are exported so the top can build the pending mask and bypass lookup.
module mmx_wb_fifo
   import mmx_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             push,
   input  mmx_wb_entry_t                    push_entry,
   input  logic                             pop,
   input  logic                             flush,
   output logic [CNT_W-1:0]                 count,
   output logic                             full,
   output logic                             empty,
   output logic [PTR_W-1:0]                 rd_ptr,
   output mmx_wb_entry_t [DEPTH-1:0]        entries,
   output logic [DEPTH-1:0]                 valid
);
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         valid  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         valid  <= '0;
      end else begin
         // Push and pop never target the same slot: that would need the FIFO empty and full at once.
         if (do_push) begin
            valid[wr_ptr] <= 1'b1;
            wr_ptr        <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            valid[rd_ptr] <= 1'b0;
            rd_ptr        <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) entries[wr_ptr] <= push_entry;
   end
endmodule

// File: rtl/mmx_writeback_stage.sv
// Final MMX stage: buffers execute results and retires one per cycle onto the register-file port.
// Define MMX_BYPASS_EN to add the byp_sel/byp_hit/byp_data forwarding lookup.
module mmx_writeback_stage
   import mmx_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int DATA_W = MMX_DATA_W,
   parameter int SEL_W  = MMX_SEL_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [DATA_W-1:0] ex_data,
   input  logic [SEL_W-1:0]  ex_dest,
   input  logic              hold,
   input  logic              flush,
   output logic [DATA_W-1:0] writeback_data,
   output logic [SEL_W-1:0]  writeback_select,
   output logic              writeback_enable,
   output logic [7:0]        pending_mask
`ifdef MMX_BYPASS_EN
  ,input  logic [SEL_W-1:0]  byp_sel,
   output logic              byp_hit,
   output logic [DATA_W-1:0] byp_data
`endif
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [CNT_W-1:0]          count;
   logic                      full;
   logic                      empty;
   logic [PTR_W-1:0]          rd_ptr;
   mmx_wb_entry_t [DEPTH-1:0] entries;
   logic [DEPTH-1:0]          valid;
   mmx_wb_entry_t             push_entry;
   logic                      retire;

   assign push_entry = '{data: ex_data, dest: ex_dest};
   // Ready comes from the registered count only, so a same-cycle pop never opens a full FIFO.
   assign ex_ready   = !full;
   assign retire     = !empty && !hold && !flush;

   mmx_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (ex_valid),
      .push_entry (push_entry),
      .pop        (!hold),
      .flush      (flush),
      .count      (count),
      .full       (full),
      .empty      (empty),
      .rd_ptr     (rd_ptr),
      .entries    (entries),
      .valid      (valid)
   );

   // Write-port register stage: data/select hold their last value while the strobe is low.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         writeback_enable <= 1'b0;
         writeback_data   <= '0;
         writeback_select <= '0;
      end else begin
         writeback_enable <= retire;
         if (retire) begin
            writeback_data   <= entries[rd_ptr].data;
            writeback_select <= entries[rd_ptr].dest;
         end
      end
   end

   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid[i]) pending_mask = pending_mask | mmx_onehot(entries[i].dest);
      end
      if (writeback_enable) pending_mask = pending_mask | mmx_onehot(writeback_select);
   end

`ifdef MMX_BYPASS_EN
   logic [PTR_W-1:0] byp_idx;

   // Scan oldest to youngest so the youngest matching entry overrides everything older.
   always_comb begin
      byp_hit  = 1'b0;
      byp_data = '0;
      byp_idx  = '0;
      if (writeback_enable && writeback_select == byp_sel) begin
         byp_hit  = 1'b1;
         byp_data = writeback_data;
      end
      for (int k = 0; k < DEPTH; k++) begin
         byp_idx = rd_ptr + PTR_W'(k);
         if (CNT_W'(k) < count && entries[byp_idx].dest == byp_sel) begin
            byp_hit  = 1'b1;
            byp_data = entries[byp_idx].data;
         end
      end
   end
`endif
endmodule
